motion_seg_fifo: RTL and testbench
==================================

// Module: motion_seg_fifo
// PURPOSE
//  Upstream feeder for motors_cont. The CPU bus assembles one motion segment: per-axis step count N,
//  per-axis step period T and an 8-bit direction mask. A commit pushes the segment into a DEPTH-entry FIFO.
//  The head segment is presented show-ahead on N/T/dir_req with steps_req = valid. motors_cont pops it
//  with a one-cycle read_ack pulse. Sticky overflow/underflow flags report to the status register.
// PARAMETERS
//  AXES   8    number of motor axes (motors_cont fixes 8)
//  DEPTH  16   segment FIFO depth, power of 2, >=2
//  AW     $clog2(DEPTH)  pointer width (derived, do not override)
// PORTS
//  clk        in   1          system clock
//  aclr       in   1          reset: synchronous, active-high
//  wr_en      in   1          bus write strobe, one cycle per word
//  wr_addr    in   5          0..7 N[i]; 8..15 T[i]; 16 dir mask; 17 commit; 18 flush; 19 clr_err
//  wr_data    in   32         bus write data
//  N          out  AXES*32    head segment step counts ([7:0][31:0])
//  T          out  AXES*32    head segment periods ([7:0][31:0])
//  dir_req    out  AXES       head segment direction mask
//  steps_req  out  1          head segment valid
//  read_ack   in   1          pop the head; one-cycle pulse from motors_cont
//  count      out  AW+1       segments stored, including the head
//  full       out  1          count == DEPTH
//  overflow   out  1          sticky: a commit was dropped because the FIFO was full
//  underflow  out  1          sticky: read_ack arrived while steps_req=0
// BEHAVIOUR
//  - Reset (aclr=1 at a clk edge): pointers=0, count=0, steps_req=0, N/T/dir_req=0, staging regs=0,
//    overflow=0, underflow=0. A reset in mid-transfer discards all stored segments and any partial staging.
//  - Staging: a write to addr 0..16 loads the matching staging register (dir mask uses wr_data[7:0]).
//    Writes to addresses 20..31 are ignored. Staging is not cleared by commit; the CPU rewrites only what changes.
//  - Commit (addr 17) pushes the staging contents as they were before this edge.
//    If full and no pop in the same cycle, the segment is dropped and overflow is set.
//  - Pop: read_ack with steps_req=1 advances the head. read_ack with steps_req=0 is ignored and sets underflow.
//  - Show-ahead latency: a commit into an empty FIFO raises steps_req and the head outputs on the next cycle.
//    After a pop, the next head (if any) is valid on the following cycle; steps_req does not drop between
//    back-to-back segments.
//  - Head outputs are held stable while steps_req=1 and no read_ack.
//  - Simultaneous commit + pop:
//    - full: both are accepted; count stays DEPTH; no overflow.
//    - exactly 1 entry: the pop retires the head; the new segment becomes the head next cycle; count stays 1.
//    - empty: the push is accepted and the pop is ignored (underflow is set).
//  - Flush (addr 18): next cycle count=0 and steps_req=0; staging and flags are kept.
//    Flush takes priority over a same-cycle read_ack.
//  - clr_err (addr 19): clears overflow/underflow. A same-cycle new error wins (the flag stays set).
//  - count arithmetic: +1 on accepted push, -1 on accepted pop, unchanged on both. Pointers wrap mod DEPTH.
//  - Segments with every N[i]=0 are stored and forwarded unchanged; motors_cont handles them.
// STRUCTURE
//  - Package cnc_motion_pkg: typedef struct packed {logic [7:0][31:0] N, T; logic [7:0] dir;} segment_t.
//    Also holds the register address constants SEG_ADDR_N/T/DIR/COMMIT/FLUSH/CLR_ERR.
//  - Sub-module seg_ram: simple dual-port, DEPTH x $bits(segment_t), registered read.
//  - This module holds the staging regs, pointers/count, head output register (FWFT prefetch) and flags.
// TESTING
//  1. Write N0=100,T0=50,dir=0x01 then commit -> next cycle steps_req=1, N[0]=100, T[0]=50, dir_req=0x01,
//     count=1; read_ack -> steps_req=0, count=0.
//  2. Commit 3 distinct segments, pop with read_ack every 4th cycle -> segments emerge in order,
//     steps_req stays high until after the 3rd pop.
//  3. Commit DEPTH+1 segments with no pops -> full=1, count=16, overflow=1, first 16 intact;
//     clr_err -> overflow=0.
//  4. Full FIFO, commit and read_ack in the same cycle -> count stays 16, overflow=0,
//     the new segment is last out.
//  5. read_ack on empty -> underflow=1, count=0; commit+read_ack on empty -> count=1, segment retained.
//  6. 5 segments stored, assert aclr mid-stream (and separately flush) -> count=0, steps_req=0;
//     with aclr staging=0, with flush staging retained.

Source files
------------

// File: rtl/cnc_motion_pkg.sv
// cnc_motion_pkg: motion segment record and CPU register map for the segment FIFO.
package cnc_motion_pkg;
    typedef struct packed {
        logic [7:0][31:0] N, T;
        logic [7:0]       dir;
    } segment_t;
    localparam logic [4:0] SEG_ADDR_N       = 5'd0;
    localparam logic [4:0] SEG_ADDR_T       = 5'd8;
    localparam logic [4:0] SEG_ADDR_DIR     = 5'd16;
    localparam logic [4:0] SEG_ADDR_COMMIT  = 5'd17;
    localparam logic [4:0] SEG_ADDR_FLUSH   = 5'd18;
    localparam logic [4:0] SEG_ADDR_CLR_ERR = 5'd19;
    localparam int SEG_W = $bits(segment_t);
endpackage

// File: rtl/seg_ram.sv
// seg_ram: simple dual-port segment store, registered read.
// A read of the address being written returns the new word, so the prefetch never sees stale data.
module seg_ram #(
    parameter int DEPTH = 16,
    parameter int W = 520,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= (i_we && i_waddr == i_raddr) ? i_wdata : r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/motion_seg_fifo.sv
// motion_seg_fifo: CPU-assembled motion segments queued show-ahead for motors_cont.
// The head lives in its own register; the RAM holds the remaining count-1 segments.
module motion_seg_fifo
    import cnc_motion_pkg::*;
#(
    parameter int AXES = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [31:0]           wr_data,
    output logic [AXES-1:0][31:0] N,
    output logic [AXES-1:0][31:0] T,
    output logic [AXES-1:0]       dir_req,
    output logic                  steps_req,
    input  logic                  read_ack,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);
    segment_t         r_stage, r_head;
    logic             r_valid, r_overflow, r_underflow;
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic [SEG_W-1:0] w_ram_q;
    logic [AW-1:0]    w_rd_addr;
    logic w_commit, w_flush, w_clr, w_full, w_pop, w_ram_empty, w_push, w_push_head;
    logic w_ram_we, w_ram_pop, w_of_new, w_uf_new;

    assign w_commit    = wr_en && wr_addr == SEG_ADDR_COMMIT;
    assign w_flush     = wr_en && wr_addr == SEG_ADDR_FLUSH;
    assign w_clr       = wr_en && wr_addr == SEG_ADDR_CLR_ERR;
    assign w_full      = r_count == (AW+1)'(DEPTH);
    assign w_pop       = read_ack && r_valid && !w_flush;
    assign w_ram_empty = r_count <= (AW+1)'(1);
    assign w_push      = w_commit && (!w_full || w_pop);
    // A push bypasses the RAM whenever the head slot is (or is becoming) free.
    assign w_push_head = w_push && (!r_valid || (w_pop && w_ram_empty));
    assign w_ram_we    = w_push && !w_push_head;
    assign w_ram_pop   = w_pop && !w_ram_empty;
    assign w_of_new    = w_commit && w_full && !w_pop;
    assign w_uf_new    = read_ack && !r_valid;
    assign w_rd_addr   = (aclr || w_flush) ? '0 : w_ram_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    seg_ram #(.DEPTH(DEPTH), .W(SEG_W)) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_stage),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_stage     <= '0;
            r_head      <= '0;
            r_valid     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && wr_addr[4:3] == SEG_ADDR_N[4:3]) r_stage.N[wr_addr[2:0]] <= wr_data;
            if (wr_en && wr_addr[4:3] == SEG_ADDR_T[4:3]) r_stage.T[wr_addr[2:0]] <= wr_data;
            if (wr_en && wr_addr == SEG_ADDR_DIR) r_stage.dir <= wr_data[7:0];
            if (w_flush) begin
                r_valid  <= 1'b0;
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_head) begin
                    r_head  <= r_stage;
                    r_valid <= 1'b1;
                end else if (w_pop) begin
                    if (!w_ram_empty) r_head <= segment_t'(w_ram_q);
                    r_valid <= !w_ram_empty;
                end
                if (w_ram_we) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_ram_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
            r_overflow  <= w_of_new || (r_overflow && !w_clr);
            r_underflow <= w_uf_new || (r_underflow && !w_clr);
        end
    end

    assign N         = r_head.N;
    assign T         = r_head.T;
    assign dir_req   = r_head.dir;
    assign steps_req = r_valid;
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
endmodule

// File: tb/tb_motion_seg_fifo.sv
// tb_motion_seg_fifo: directed and random stimulus against a queue-based segment FIFO model.
module tb_motion_seg_fifo;
    import cnc_motion_pkg::*;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             aclr, wr_en, read_ack;
    logic [4:0]       wr_addr;
    logic [31:0]      wr_data;
    logic [7:0][31:0] N, T;
    logic [7:0]       dir_req;
    logic             steps_req, full, overflow, underflow;
    logic [4:0]       count;

    segment_t m_q[$];
    segment_t m_stage;
    bit       m_of, m_uf;
    int       checks = 0, passed = 0, fails = 0;

    always #5 clk = ~clk;

    motion_seg_fifo #(.AXES(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .aclr(aclr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .N(N), .T(T), .dir_req(dir_req), .steps_req(steps_req), .read_ack(read_ack),
        .count(count), .full(full), .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string tag, input logic [SEG_W-1:0] obs, input logic [SEG_W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic a, input logic we, input logic [4:0] ad,
                         input logic [31:0] d, input logic ack);
        bit commit, flush, clr, pop, of, uf;
        if (a) begin
            m_q.delete();
            m_stage = '0;
            m_of = 0;
            m_uf = 0;
        end else begin
            commit = we && ad == 5'd17;
            flush  = we && ad == 5'd18;
            clr    = we && ad == 5'd19;
            pop    = ack && m_q.size() > 0 && !flush;
            uf     = ack && m_q.size() == 0;
            of     = commit && m_q.size() == DEPTH && !pop;
            if (flush) m_q.delete();
            else begin
                if (pop) void'(m_q.pop_front());
                if (commit && !of) m_q.push_back(m_stage);
            end
            if (we && ad < 5'd8) m_stage.N[ad[2:0]] = d;
            else if (we && ad < 5'd16) m_stage.T[ad[2:0]] = d;
            else if (we && ad == 5'd16) m_stage.dir = d[7:0];
            m_of = of || (m_of && !clr);
            m_uf = uf || (m_uf && !clr);
        end
    endtask

    task automatic check_outputs();
        chk("count", SEG_W'(count), SEG_W'(m_q.size()));
        chk("full", SEG_W'(full), SEG_W'(m_q.size() == DEPTH));
        chk("steps_req", SEG_W'(steps_req), SEG_W'(m_q.size() != 0));
        chk("overflow", SEG_W'(overflow), SEG_W'(m_of));
        chk("underflow", SEG_W'(underflow), SEG_W'(m_uf));
        if (m_q.size() > 0) chk("head", {N, T, dir_req}, m_q[0]);
    endtask

    task automatic step(input logic a, input logic we, input logic [4:0] ad,
                        input logic [31:0] d, input logic ack);
        aclr = a; wr_en = we; wr_addr = ad; wr_data = d; read_ack = ack;
        @(posedge clk);
        model(a, we, ad, d, ack);
        #1;
        check_outputs();
    endtask

    task automatic wr(input logic [4:0] ad, input logic [31:0] d);
        step(1'b0, 1'b1, ad, d, 1'b0);
    endtask

    task automatic commit(input logic ack);
        step(1'b0, 1'b1, 5'd17, 32'd0, ack);
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 1'b0, 5'd0, 32'd0, ack);
    endtask

    initial begin
        aclr = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; read_ack = 1'b0;
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("reset_head", {N, T, dir_req}, '0);
        // single segment round trip
        wr(5'd0, 32'd100);
        wr(5'd8, 32'd50);
        wr(5'd16, 32'h01);
        commit(1'b0);
        chk("t1_N0", SEG_W'(N[0]), SEG_W'(100));
        chk("t1_T0", SEG_W'(T[0]), SEG_W'(50));
        chk("t1_dir", SEG_W'(dir_req), SEG_W'(8'h01));
        idle(1'b1);
        idle(1'b0);
        // three segments, popped every 4th cycle
        for (int i = 0; i < 3; i++) begin
            wr(5'd1, 32'(1000 + i));
            wr(5'd9, 32'(2000 + i));
            commit(1'b0);
        end
        for (int i = 0; i < 14; i++) idle(i % 4 == 3);
        // overflow on DEPTH+1 commits, then clear, then drain in order
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr(5'd0, 32'(i));
            commit(1'b0);
        end
        wr(5'd19, 32'd0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        // full with simultaneous commit and pop
        for (int i = 0; i < DEPTH; i++) begin
            wr(5'd2, 32'(300 + i));
            commit(1'b0);
        end
        wr(5'd2, 32'd999);
        commit(1'b1);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        wr(5'd19, 32'd0);
        // underflow and commit+pop on empty
        idle(1'b1);
        wr(5'd3, 32'h55);
        commit(1'b1);
        idle(1'b0);
        idle(1'b1);
        // reset mid-stream discards data and staging
        for (int i = 0; i < 5; i++) begin
            wr(5'd4, 32'(40 + i));
            commit(1'b0);
        end
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        commit(1'b0);
        idle(1'b1);
        // flush keeps staging
        for (int i = 0; i < 5; i++) begin
            wr(5'd5, 32'(50 + i));
            wr(5'd16, 32'(i));
            commit(1'b0);
        end
        step(1'b0, 1'b1, 5'd18, 32'd0, 1'b1);
        commit(1'b0);
        idle(1'b1);
        // random traffic, first commit-heavy then pop-heavy
        for (int i = 0; i < 2000; i++) begin
            int pick;
            logic [4:0] ad;
            pick = $urandom_range(0, 19);
            ad = pick < 10 ? 5'($urandom_range(0, 16)) :
                 pick < 16 ? 5'd17 :
                 pick == 16 ? ($urandom_range(0, 3) == 0 ? 5'd18 : 5'd17) :
                 pick == 17 ? 5'd19 : 5'($urandom_range(0, 31));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, ad, $urandom,
                 i < 1000 ? $urandom_range(0, 7) == 0 : $urandom_range(0, 1) == 0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
